gshare_spec_predictor: RTL and testbench

//  Parametrised gshare direction predictor with speculative global history and recovery.

---
 rtl/br_pred_pkg.sv | 35 +++
 rtl/pred_counter_table.sv | 43 ++++
 rtl/gshare_spec_predictor.sv | 105 ++++++++++
 tb/tb_gshare_spec_predictor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pred_pkg.sv
// Purpose: shared helpers for branch direction predictors (counter update, reset value, history shift).
// Latency: n/a (pure functions, evaluated combinationally or at elaboration).
// Backpressure: n/a.
//
// All helpers operate on 32-bit containers. Callers zero-extend their operands
// and truncate the result back to the real width, so one function serves every
// parameterisation.

package br_pred_pkg;

  // Saturating up/down counter step: clamps at 2^ctr_w-1 and at 0, never wraps.
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          ctr_w);
    logic [31:0] ctr_max;
    ctr_max = (32'd1 << ctr_w) - 32'd1;
    if (taken) begin
      return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

  // Weakly not-taken: the value just below the taken/not-taken threshold.
  function automatic logic [31:0] ctr_init(input int ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Shift a new outcome into the LSB. The caller's truncation drops the oldest
  // bit, which also makes a 1-bit history degenerate to "hist <= new_bit".
  function automatic logic [31:0] hist_shift(input logic [31:0] hist,
                                             input logic        new_bit);
    return (hist << 1) | {31'd0, new_bit};
  endfunction

endpackage

// File: rtl/pred_counter_table.sv
// Purpose: pattern history table of saturating counters, async-reset flop array.
// Latency: read is combinational (0 cycles); write lands at the next clk edge.
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ridx / rdata      combinational read port (returns pre-write value on a same-index write)
//   we, widx, taken   write port: step counter[widx] up (taken) or down, saturating

module pred_counter_table
  import br_pred_pkg::*;
#(
  parameter int PHT_IDX_W = 8,
  parameter int CTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PHT_IDX_W-1:0] ridx,
  output logic [CTR_W-1:0]     rdata,
  input  logic                 we,
  input  logic [PHT_IDX_W-1:0] widx,
  input  logic                 taken
);

  localparam int               ENTRIES = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] ctr_q [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (we) begin
      ctr_q[widx] <= CTR_W'(sat_ctr_next(32'(ctr_q[widx]), taken, CTR_W));
    end
  end

  // No write-to-read bypass: a same-cycle update is only visible next cycle.
  assign rdata = ctr_q[ridx];

endmodule

// File: rtl/gshare_spec_predictor.sv
// Purpose: gshare direction predictor with speculative global history and mispredict/flush recovery.
// Latency: prediction is combinational (0 cycles); training and history updates land at the next edge.
// Backpressure: none; a prediction and an update are accepted every cycle.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   pred_req, pred_pc              fetch-side branch lookup
//   pred_taken, pred_idx, pred_hist  prediction plus the index/history checkpoint to carry down the pipe
//   upd_valid, upd_idx, upd_hist, upd_taken, upd_mispredict  resolved-branch training/recovery
//   flush                          front-end flush: speculative history falls back to committed history
//   spec_hist_o, arch_hist_o       speculative and committed history, for observation

module gshare_spec_predictor
  import br_pred_pkg::*;
#(
  parameter int PHT_IDX_W = 8,
  parameter int HIST_W    = 8,
  parameter int PC_LSB    = 2,
  parameter int CTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_req,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  output logic [HIST_W-1:0]    pred_hist,
  input  logic                 upd_valid,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic [HIST_W-1:0]    upd_hist,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  input  logic                 flush,
  output logic [HIST_W-1:0]    spec_hist_o,
  output logic [HIST_W-1:0]    arch_hist_o
);

  logic [HIST_W-1:0]    spec_hist;
  logic [HIST_W-1:0]    arch_hist;
  logic [HIST_W-1:0]    spec_next;
  logic [HIST_W-1:0]    arch_next;
  logic [PHT_IDX_W-1:0] idx;
  logic [CTR_W-1:0]     rd_ctr;

  // Only the PC index slice, the upper history bits that shift out, and the
  // counter MSB matter; the rest is intentionally ignored.
  logic [32+HIST_W+CTR_W-1:0] unused_sigs;
  assign unused_sigs = {pred_pc, upd_hist, rd_ctr};

  // History is zero-extended on the left, so it folds into the low index bits
  // when HIST_W < PHT_IDX_W.
  assign idx        = pred_pc[PC_LSB +: PHT_IDX_W] ^ PHT_IDX_W'(spec_hist);
  assign pred_taken = rd_ctr[CTR_W-1];
  assign pred_idx   = idx;
  assign pred_hist  = spec_hist;

  pred_counter_table #(
    .PHT_IDX_W (PHT_IDX_W),
    .CTR_W     (CTR_W)
  ) u_pht (
    .clk   (clk),
    .rst   (rst),
    .ridx  (idx),
    .rdata (rd_ctr),
    .we    (upd_valid),
    .widx  (upd_idx),
    .taken (upd_taken)
  );

  always_comb begin
    arch_next = arch_hist;
    if (upd_valid) begin
      arch_next = HIST_W'(hist_shift(32'(arch_hist), upd_taken));
    end
  end

  // Flush outranks mispredict recovery, which outranks the speculative shift.
  // Flush copies the post-update committed history so a branch resolving in
  // the same cycle is not lost. A coinciding pred_req is dropped: fetch is
  // being redirected anyway.
  always_comb begin
    spec_next = spec_hist;
    if (flush) begin
      spec_next = arch_next;
    end else if (upd_valid && upd_mispredict) begin
      spec_next = HIST_W'(hist_shift(32'(upd_hist), upd_taken));
    end else if (pred_req) begin
      spec_next = HIST_W'(hist_shift(32'(spec_hist), pred_taken));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_hist <= '0;
      arch_hist <= '0;
    end else begin
      spec_hist <= spec_next;
      arch_hist <= arch_next;
    end
  end

  assign spec_hist_o = spec_hist;
  assign arch_hist_o = arch_hist;

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Purpose: directed self-checking bench for gshare_spec_predictor (default parameters).
// Latency: inputs change just after the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
// Backpressure: n/a.

module tb_gshare_spec_predictor;

  localparam int PHT_IDX_W = 8;
  localparam int HIST_W    = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 pred_req;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic [HIST_W-1:0]    pred_hist;
  logic                 upd_valid;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic [HIST_W-1:0]    upd_hist;
  logic                 upd_taken;
  logic                 upd_mispredict;
  logic                 flush;
  logic [HIST_W-1:0]    spec_hist_o;
  logic [HIST_W-1:0]    arch_hist_o;

  always #5 clk = ~clk;

  gshare_spec_predictor #(
    .PHT_IDX_W (PHT_IDX_W),
    .HIST_W    (HIST_W),
    .PC_LSB    (2),
    .CTR_W     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_hist      (pred_hist),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_hist       (upd_hist),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .flush          (flush),
    .spec_hist_o    (spec_hist_o),
    .arch_hist_o    (arch_hist_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Queue the value the next check must see.
  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against what the DUT shows now.
  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    pred_req       = 1'b0;
    upd_valid      = 1'b0;
    upd_idx        = '0;
    upd_hist       = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;

    // ---------------- Test 1: reset state ----------------
    rst     = 1'b0;
    pred_pc = 32'h40;
    idle();
    repeat (2) @(negedge clk);
    #1;
    expect_val("rst_pred_taken", 0);  check(32'(pred_taken));
    expect_val("rst_pred_idx", 32'h10); check(32'(pred_idx));
    expect_val("rst_pred_hist", 0);   check(32'(pred_hist));
    expect_val("rst_spec_hist", 0);   check(32'(spec_hist_o));
    expect_val("rst_arch_hist", 0);   check(32'(arch_hist_o));
    rst = 1'b1;
    next_cycle();

    // ---------------- Test 2: saturation at top ----------------
    for (int k = 1; k <= 5; k++) begin
      upd_valid = 1'b1;
      upd_idx   = 8'h10;
      upd_taken = 1'b1;
      next_cycle();
      if (k == 1 || k >= 4) begin
        expect_val($sformatf("sat_hi_after_%0d", k), 1);
        check(32'(pred_taken));
      end
    end

    // Saturation at bottom on idx 0x20 (history still 0, pc 0x80 -> idx 0x20)
    upd_valid = 1'b0;
    pred_pc   = 32'h80;
    #1;
    expect_val("sat_lo_init", 0); check(32'(pred_taken));
    upd_valid = 1'b1;
    upd_idx   = 8'h20;
    upd_taken = 1'b0;
    next_cycle();                 // counter 0
    next_cycle();                 // stays 0
    upd_taken = 1'b1;
    next_cycle();                 // back to 1
    #1;
    expect_val("sat_lo_floor", 0); check(32'(pred_taken));
    next_cycle();                 // 2
    upd_valid = 1'b0;
    #1;
    expect_val("sat_lo_recover", 1); check(32'(pred_taken));
    // Update outcomes so far: 1,1,1,1,1,0,0,1,1 -> last eight = 0xF3
    expect_val("arch_after_train", 32'hF3); check(32'(arch_hist_o));
    expect_val("spec_untouched", 0);         check(32'(spec_hist_o));

    // ---------------- Test 3: speculative shift ----------------
    pred_req = 1'b1;
    pred_pc  = 32'h40;            // idx 0x10 ^ 0x00
    #1;
    expect_val("spec0_taken", 1);    check(32'(pred_taken));
    expect_val("spec0_idx", 32'h10); check(32'(pred_idx));
    expect_val("spec0_hist", 0);     check(32'(pred_hist));
    next_cycle();
    pred_pc = 32'h44;             // idx 0x11 ^ 0x01 = 0x10
    #1;
    expect_val("spec1_taken", 1);    check(32'(pred_taken));
    expect_val("spec1_hist", 1);     check(32'(pred_hist));
    next_cycle();
    pred_pc = 32'h4C;             // idx 0x13 ^ 0x03 = 0x10
    #1;
    expect_val("spec2_taken", 1);    check(32'(pred_taken));
    expect_val("spec2_hist", 3);     check(32'(pred_hist));
    next_cycle();
    pred_req = 1'b0;
    #1;
    expect_val("spec_hist_07", 32'h07); check(32'(spec_hist_o));

    // ---------------- Test 4: mispredict recovery beats pred_req ----------------
    pred_req       = 1'b1;
    pred_pc        = 32'h40;
    upd_valid      = 1'b1;
    upd_mispredict = 1'b1;
    upd_hist       = 8'h01;
    upd_taken      = 1'b0;
    upd_idx        = 8'h30;
    #1;
    expect_val("hashed_idx_17", 32'h17); check(32'(pred_idx));
    next_cycle();
    idle();
    #1;
    expect_val("recover_spec", 32'h02); check(32'(spec_hist_o));
    expect_val("recover_arch", 32'hE6); check(32'(arch_hist_o));

    // ---------------- Test 5: flush wins over mispredict ----------------
    pat = 8'b0000_0101;
    for (int i = 7; i >= 0; i--) begin
      upd_valid = 1'b1;
      upd_idx   = 8'h30;
      upd_taken = pat[i];
      next_cycle();
    end
    idle();
    #1;
    expect_val("arch_preflush", 32'h05); check(32'(arch_hist_o));
    expect_val("spec_preflush", 32'h02); check(32'(spec_hist_o));
    flush          = 1'b1;
    upd_valid      = 1'b1;
    upd_idx        = 8'h30;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    upd_hist       = 8'h00;
    pred_req       = 1'b1;
    pred_pc        = 32'h40;
    next_cycle();
    idle();
    #1;
    expect_val("flush_spec", 32'h0B); check(32'(spec_hist_o));
    expect_val("flush_arch", 32'h0B); check(32'(arch_hist_o));

    // ---------------- Test 6: same-cycle read/write, no bypass ----------------
    pred_req  = 1'b1;
    pred_pc   = 32'h12C;          // slice 0x4B ^ 0x0B = 0x40
    upd_valid = 1'b1;
    upd_idx   = 8'h40;
    upd_taken = 1'b1;
    #1;
    expect_val("rw_idx_now", 32'h40); check(32'(pred_idx));
    expect_val("rw_old_value", 0);    check(32'(pred_taken));
    next_cycle();
    upd_valid = 1'b0;
    pred_pc   = 32'h158;          // slice 0x56 ^ 0x16 = 0x40
    #1;
    expect_val("rw_idx_next", 32'h40); check(32'(pred_idx));
    expect_val("rw_new_value", 1);     check(32'(pred_taken));
    expect_val("rw_spec", 32'h16);     check(32'(spec_hist_o));
    expect_val("rw_arch", 32'h17);     check(32'(arch_hist_o));

    // ---------------- Reset mid-stream with a pending update ----------------
    next_cycle();
    pred_req  = 1'b0;
    upd_valid = 1'b1;
    upd_idx   = 8'h10;
    upd_taken = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    expect_val("midrst_spec", 0); check(32'(spec_hist_o));
    expect_val("midrst_arch", 0); check(32'(arch_hist_o));
    next_cycle();
    idle();
    rst     = 1'b1;
    pred_pc = 32'h40;
    #1;
    expect_val("post_rst_idx", 32'h10); check(32'(pred_idx));
    expect_val("post_rst_c10", 0);      check(32'(pred_taken));
    pred_pc = 32'h100;
    #1;
    expect_val("post_rst_c40", 0);      check(32'(pred_taken));
    // One taken step must reach the threshold only if the counter is back at 1
    upd_valid = 1'b1;
    upd_idx   = 8'h10;
    upd_taken = 1'b1;
    next_cycle();
    upd_idx = 8'h40;
    pred_pc = 32'h40;
    #1;
    expect_val("post_rst_c10_step", 1); check(32'(pred_taken));
    next_cycle();
    idle();
    pred_pc = 32'h100;
    #1;
    expect_val("post_rst_c40_step", 1); check(32'(pred_taken));
    expect_val("post_rst_spec", 0);     check(32'(spec_hist_o));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
